// File: rtl/eth_payload_ser.sv
// eth_payload_ser: pulls 32-bit payload words from a packet source and
// serialises them MSB-byte-first onto a valid/ready byte stream, padding
// short packets up to MIN_PAYLOAD bytes before pulsing eth_tx_done.
module eth_payload_ser #(
    parameter int          MIN_PAYLOAD = 18,
    parameter int          MAX_BYTES   = 1472,
    parameter logic [7:0]  PAD_BYTE    = 8'h00
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        eth_tx_start,
    input  logic [15:0] eth_tx_data_num,
    input  logic [31:0] eth_tx_data,
    output logic        eth_tx_req,
    output logic        eth_tx_done,
    output logic [7:0]  pl_data,
    output logic        pl_valid,
    input  logic        pl_ready,
    output logic        pl_last,
    output logic [15:0] pl_len,
    output logic        pl_busy,
    output logic        pl_err
);

    typedef enum logic [2:0] {
        IDLE, REQ, CAP, SEND, PAD, DONE
    } state_t;

    localparam logic [15:0] MIN_LEN = 16'(MIN_PAYLOAD);
    localparam logic [15:0] MAX_LEN = 16'(MAX_BYTES);

    state_t      state, state_nxt;
    logic [15:0] n_lat;      // requested payload bytes of the current packet
    logic [15:0] byte_cnt;   // bytes accepted so far (payload + pad)
    logic [1:0]  word_idx;   // byte position inside the current word
    logic [31:0] shift;      // current word, next byte always in [31:24]

    logic        start_ok;
    logic [15:0] cnt_inc;

    assign start_ok = eth_tx_start && (eth_tx_data_num != 16'd0)
                      && (eth_tx_data_num <= MAX_LEN);
    assign cnt_inc  = byte_cnt + 16'd1;

    // State register.
    always_ff @(posedge sys_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (sys_rst) state <= IDLE;
        else         state <= state_nxt;
    end

    // Next-state and per-state outputs.
    always_comb begin
        // NOTE: every output gets a default first; a path that leaves one
        // unassigned would infer a latch.
        state_nxt   = state;
        eth_tx_req  = 1'b0;
        eth_tx_done = 1'b0;
        pl_valid    = 1'b0;
        pl_data     = 8'h00;
        case (state)
            IDLE: if (start_ok) state_nxt = REQ;
            REQ: begin
                eth_tx_req = 1'b1;
                state_nxt  = CAP;
            end
            CAP: state_nxt = SEND;
            SEND: begin
                pl_valid = 1'b1;
                pl_data  = shift[31:24];
                // Leave the word after its 4th byte or at the payload end;
                // any remaining bytes of a final partial word are dropped.
                if (pl_ready && (word_idx == 2'd3 || cnt_inc == n_lat)) begin
                    if (cnt_inc < n_lat)      state_nxt = REQ;
                    else if (n_lat < MIN_LEN) state_nxt = PAD;
                    else                      state_nxt = DONE;
                end
            end
            PAD: begin
                pl_valid = 1'b1;
                pl_data  = PAD_BYTE;
                if (pl_ready && cnt_inc == pl_len) state_nxt = DONE;
            end
            DONE: begin
                eth_tx_done = 1'b1;
                state_nxt   = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Final byte of the emitted frame, payload or pad.
    assign pl_last = pl_valid && (byte_cnt == pl_len - 16'd1);

    // Datapath: packet setup, word capture, byte shifting and counting.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            n_lat    <= 16'd0;
            byte_cnt <= 16'd0;
            word_idx <= 2'd0;
            shift    <= 32'd0;
            pl_len   <= 16'd0;
            pl_busy  <= 1'b0;
            pl_err   <= 1'b0;
        end else begin
            pl_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (eth_tx_start) begin
                        if (start_ok) begin
                            n_lat    <= eth_tx_data_num;
                            pl_len   <= (eth_tx_data_num < MIN_LEN) ? MIN_LEN
                                                                    : eth_tx_data_num;
                            pl_busy  <= 1'b1;
                            byte_cnt <= 16'd0;
                        end else begin
                            pl_err <= 1'b1;
                        end
                    end
                end
                CAP: begin
                    shift    <= eth_tx_data;
                    word_idx <= 2'd0;
                end
                SEND: begin
                    if (pl_ready) begin
                        shift    <= {shift[23:0], 8'h00};
                        byte_cnt <= cnt_inc;
                        word_idx <= word_idx + 2'd1;
                    end
                end
                PAD: begin
                    if (pl_ready) byte_cnt <= cnt_inc;
                end
                DONE: pl_busy <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule
